// File: rtl/miriscv_mdu_pkg.sv
// MDU shared types: op encodings, divide-control states
// and the signed-overflow dividend constant.
package miriscv_mdu_pkg;

  localparam int XLEN         = 32;
  localparam int MDU_OP_WIDTH = 3;

  typedef logic [MDU_OP_WIDTH-1:0] mdu_op_t;

  localparam mdu_op_t MDU_MUL    = 3'd0;
  localparam mdu_op_t MDU_MULH   = 3'd1;
  localparam mdu_op_t MDU_MULHSU = 3'd2;
  localparam mdu_op_t MDU_MULHU  = 3'd3;
  localparam mdu_op_t MDU_DIV    = 3'd4;
  localparam mdu_op_t MDU_DIVU   = 3'd5;
  localparam mdu_op_t MDU_REM    = 3'd6;
  localparam mdu_op_t MDU_REMU   = 3'd7;

  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_ctrl_state_t;

  function automatic logic is_div_op(input mdu_op_t op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_rem_op(input mdu_op_t op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_signed_op(input mdu_op_t op);
    return op inside {MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/miriscv_div_ctrl_if.sv
// Control/data bundle between the divide front-end
// (master) and the iterative divider (slave).
interface miriscv_div_ctrl_if;
  import miriscv_mdu_pkg::*;

  logic            start;
  logic            zero;
  logic            kill;
  logic            keep;
  logic            stall_req;
  logic [XLEN-1:0] port_a;
  logic [XLEN-1:0] port_b;
  logic [XLEN-1:0] div_result;
  logic [XLEN-1:0] rem_result;
  mdu_op_t         op;

  modport master (
    output start, zero, kill, keep,
    output port_a, port_b, op,
    input  stall_req, div_result, rem_result
  );

  modport slave (
    input  start, zero, kill, keep,
    input  port_a, port_b, op,
    output stall_req, div_result, rem_result
  );

endinterface

// File: rtl/miriscv_div_fuse_cache.sv
// One-entry quotient/remainder cache for DIV/REM fusion.
// Only built with MIRISCV_DIV_REM_FUSE_EN defined.
`ifdef MIRISCV_DIV_REM_FUSE_EN
module miriscv_div_fuse_cache
  import miriscv_mdu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush,
  input  logic            wr,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sgn,
  input  logic            rem_sel,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] rem,
  output logic            hit,
  output logic [XLEN-1:0] data
);

  logic            valid_q;
  logic            sgn_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) valid_q <= 1'b0;
    else if (wr)        valid_q <= 1'b1;
  end

  // Payload needs no reset: valid_q gates every use.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      a_q    <= a;
      b_q    <= b;
      sgn_q  <= sgn;
      quot_q <= quot;
      rem_q  <= rem;
    end
  end

  assign hit  = valid_q && (a_q == a) &&
                (b_q == b) && (sgn_q == sgn);
  assign data = rem_sel ? rem_q : quot_q;

endmodule
`endif

// File: rtl/miriscv_div_ctrl.sv
// Divide-path front-end of the MDU: overflow short-cut,
// divider handshake, result capture. Option: MIRISCV_DIV_REM_FUSE_EN.
module miriscv_div_ctrl
  import miriscv_mdu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mdu_req_i,
  input  mdu_op_t         mdu_op_i,
  input  logic [XLEN-1:0] port_a_i,
  input  logic [XLEN-1:0] port_b_i,
  input  logic            kill_i,
  input  logic            keep_i,
  output logic [XLEN-1:0] mdu_result_o,
  output logic            mdu_stall_req_o,
  miriscv_div_ctrl_if.master div
);

  div_ctrl_state_t state_q, state_d;

  logic            div_req;
  logic            rem_op;
  logic            sgn_op;
  logic            ovf;
  logic            hit;
  logic            capture;
  logic [XLEN-1:0] ovf_res;
  logic [XLEN-1:0] cap_res;
  logic [XLEN-1:0] hit_res;
  logic [XLEN-1:0] result_q;

  assign div_req = mdu_req_i && is_div_op(mdu_op_i);
  assign rem_op  = is_rem_op(mdu_op_i);
  assign sgn_op  = is_signed_op(mdu_op_i);
  assign ovf     = sgn_op && (port_a_i == DIV_OVF_DIVIDEND)
                   && (&port_b_i);
  assign ovf_res = rem_op ? '0 : DIV_OVF_DIVIDEND;
  assign cap_res = rem_op ? div.rem_result : div.div_result;
  assign capture = (state_q == BUSY) && !div.stall_req
                   && !kill_i;

`ifdef MIRISCV_DIV_REM_FUSE_EN
  miriscv_div_fuse_cache u_fuse (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush   (kill_i),
    .wr      (capture),
    .a       (port_a_i),
    .b       (port_b_i),
    .sgn     (sgn_op),
    .rem_sel (rem_op),
    .quot    (div.div_result),
    .rem     (div.rem_result),
    .hit     (hit),
    .data    (hit_res)
  );
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (div_req)
              state_d = (ovf || hit) ? DONE : BUSY;
      BUSY: if (!div.stall_req) state_d = DONE;
      DONE: if (!keep_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // keep drops with the capture so the divider can retire.
  always_comb begin
    div.start       = 1'b0;
    div.keep        = 1'b0;
    div.zero        = 1'b0;
    mdu_stall_req_o = 1'b0;
    unique case (state_q)
      IDLE: mdu_stall_req_o = div_req;
      BUSY: begin
        div.start       = 1'b1;
        div.keep        = div.stall_req;
        div.zero        = ~|port_b_i;
        mdu_stall_req_o = div_req;
      end
      default: ;
    endcase
  end

  assign div.kill   = kill_i;
  assign div.port_a = port_a_i;
  assign div.port_b = port_b_i;
  assign div.op     = mdu_op_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
    end else if (!kill_i) begin
      if ((state_q == IDLE) && div_req && ovf)
        result_q <= ovf_res;
      else if ((state_q == IDLE) && div_req && hit)
        result_q <= hit_res;
      else if (capture)
        result_q <= cap_res;
    end
  end

  assign mdu_result_o = result_q;

endmodule

// File: tb/tb_miriscv_div_ctrl.sv
// Scoreboard bench for miriscv_div_ctrl with a
// behavioural iterative divider behind the interface.
module tb_miriscv_div_ctrl;
  import miriscv_mdu_pkg::*;

  localparam int LAT  = 20;
  localparam int FULL = LAT + 2;
`ifdef MIRISCV_DIV_REM_FUSE_EN
  localparam int PAIR = 1;
`else
  localparam int PAIR = FULL;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic            kill;
  logic            keep;
  mdu_op_t         op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            stall;

  miriscv_div_ctrl_if div ();

  miriscv_div_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .mdu_req_i       (req),
    .mdu_op_i        (op),
    .port_a_i        (a),
    .port_b_i        (b),
    .kill_i          (kill),
    .keep_i          (keep),
    .mdu_result_o    (result),
    .mdu_stall_req_o (stall),
    .div             (div)
  );

  always #5 clk = ~clk;

  int cnt;
  always @(posedge clk) begin
    if (rst || div.kill || !div.start) cnt <= 0;
    else if (cnt < LAT)                cnt <= cnt + 1;
    else if (!div.keep)                cnt <= 0;
  end

  logic [XLEN-1:0] q_m, r_m;
  always_comb begin
    q_m = '1;
    r_m = div.port_a;
    if (div.port_b != 0) begin
      if (div.op inside {MDU_DIVU, MDU_REMU}) begin
        q_m = div.port_a / div.port_b;
        r_m = div.port_a % div.port_b;
      end else if (div.port_a == 32'h8000_0000 &&
                   div.port_b == 32'hFFFF_FFFF) begin
        q_m = div.port_a;
        r_m = '0;
      end else begin
        q_m = $signed(div.port_a) / $signed(div.port_b);
        r_m = $signed(div.port_a) % $signed(div.port_b);
      end
    end
  end

  // Results are garbage until the divider has finished.
  assign div.stall_req  = div.start && (cnt < LAT);
  assign div.div_result = (cnt == LAT) ? q_m : 32'hDEAD_BEEF;
  assign div.rem_result = (cnt == LAT) ? r_m : 32'hDEAD_BEEF;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [XLEN-1:0] sb_q[$];
  logic [XLEN-1:0] last;
  bit              saw_start;
  bit              saw_zero;
  int              n_stall;
  int              cnt_done;

  task automatic run_op(input string nm, input mdu_op_t o,
                        input logic [XLEN-1:0] oa,
                        input logic [XLEN-1:0] ob,
                        input logic [XLEN-1:0] ex,
                        input int lat);
    logic [XLEN-1:0] exp_r;
    bit done;
    @(posedge clk); #1;
    req = 1'b1; op = o; a = oa; b = ob;
    sb_q.push_back(ex);
    saw_start = 0; saw_zero = 0; n_stall = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (div.start) saw_start = 1;
      if (div.start && div.zero) saw_zero = 1;
      if (stall) n_stall++;
      else done = 1;
    end
    cnt_done = cnt;
    exp_r = sb_q.pop_front();
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: stall high 200 cycles", nm);
    end else begin
      if (result !== exp_r) begin
        n_bad++;
        $display("FAIL %s result: got %h want %h",
                 nm, result, exp_r);
      end
      n_cmp++;
      if (n_stall !== lat) begin
        n_bad++;
        $display("FAIL %s stall cycles: got %0d want %0d",
                 nm, n_stall, lat);
      end
    end
    last = exp_r;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; kill = 1'b0; keep = 1'b0;
    op = MDU_DIVU; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset result", result, 32'h0);
    chk("reset ctrl",
        {28'h0, div.start, div.keep, div.zero, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_divu();
    run_op("divu 100/7", MDU_DIVU, 100, 7, 14, FULL);
    chk("divu started", {31'h0, saw_start}, 32'h1);
    chk("divu zero", {31'h0, saw_zero}, 32'h0);
    chk("divider idle", cnt_done, 32'h0);
  endtask

  task automatic test_signed();
    run_op("rem -7/2", MDU_REM, 32'hFFFF_FFF9, 2,
           32'hFFFF_FFFF, FULL);
    run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 2,
           32'hFFFF_FFFD, PAIR);
  endtask

  task automatic test_overflow();
    run_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    chk("div ovf start", {31'h0, saw_start}, 32'h0);
    run_op("rem ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 1);
    chk("rem ovf start", {31'h0, saw_start}, 32'h0);
  endtask

  task automatic test_div_zero();
    run_op("divu /0", MDU_DIVU, 32'h1234, 0,
           32'hFFFF_FFFF, FULL);
    chk("divu /0 zero", {31'h0, saw_zero}, 32'h1);
    run_op("remu /0", MDU_REMU, 32'h1234, 0, 32'h1234, PAIR);
  endtask

  task automatic test_keep();
    keep = 1'b1;
    run_op("keep divu", MDU_DIVU, 50, 5, 10, FULL);
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("keep hold stall", {31'h0, stall}, 32'h0);
    end
    chk("keep result", result, 32'd10);
    @(posedge clk); #1;
    keep = 1'b0; req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_kill();
    @(posedge clk); #1;
    req = 1'b1; op = MDU_DIVU; a = 1000; b = 3;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    chk("kill out", {31'h0, div.kill}, 32'h1);
    @(posedge clk); #1;
    kill = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("kill idle start", {31'h0, div.start}, 32'h0);
    chk("kill result", result, last);
    run_op("divu 9/3", MDU_DIVU, 9, 3, 3, FULL);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req = 1'b1; op = MDU_DIVU; a = 77; b = 7;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst mid start", {31'h0, div.start}, 32'h0);
    chk("rst mid result", result, 32'h0);
    run_op("divu after rst", MDU_DIVU, 77, 7, 11, FULL);
  endtask

`ifdef MIRISCV_DIV_REM_FUSE_EN
  task automatic test_fuse();
    run_op("fuse div", MDU_DIV, 100, 7, 14, FULL);
    run_op("fuse rem hit", MDU_REM, 100, 7, 2, 1);
    chk("fuse hit start", {31'h0, saw_start}, 32'h0);
    run_op("fuse remu miss", MDU_REMU, 100, 7, 2, FULL);
    chk("fuse miss start", {31'h0, saw_start}, 32'h1);
    @(posedge clk); #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    run_op("fuse after kill", MDU_REMU, 100, 7, 2, FULL);
  endtask
`endif

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_overflow();
    test_div_zero();
    test_keep();
    test_kill();
    test_reset_mid();
`ifdef MIRISCV_DIV_REM_FUSE_EN
    test_fuse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/miriscv_div_ctrl.md
Name: miriscv_div_ctrl

Overview:
- Divide-path front-end of the MDU. Sits between the execute stage and miriscv_div.
- Accepts DIV/DIVU/REM/REMU requests and short-cuts signed overflow. Otherwise sequences the divider handshake (start/zero/keep/kill).
- Captures the quotient or remainder into a result register and drives a single pipeline stall request.
- Optional feature: fuses a DIV/REM pair on identical operands.

Parameters:
- XLEN, 32, operand width; taken from miriscv_pkg, not overridable per instance.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- mdu_req_i  in  1  request valid, held by pipeline until stall drops
- mdu_op_i  in  MDU_OP_WIDTH  operation; MDU_DIV/DIVU/REM/REMU accepted
- port_a_i  in  XLEN  dividend
- port_b_i  in  XLEN  divisor
- kill_i  in  1  pipeline flush
- keep_i  in  1  downstream hold
- mdu_result_o  out  XLEN  registered result
- mdu_stall_req_o  out  1  stall pipeline
- div_start_o  out  1  to divider div_start_i
- div_port_a_o / div_port_b_o  out  XLEN  to divider operand ports
- div_op_o  out  MDU_OP_WIDTH  to divider mdu_op_i
- div_zero_o  out  1  divisor==0
- div_kill_o  out  1  to divider kill_i
- div_keep_o  out  1  to divider keep_i
- div_result_i  in  XLEN  quotient from divider
- rem_result_i  in  XLEN  remainder from divider
- div_stall_req_i  in  1  divider busy (start && !done)

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE; mdu_result_o=0, cache invalid; all div_* control outputs 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Idle when mdu_req_i=0 or the op is not a divide op. In that case stall=0 and no action.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): load result (DIV→0x80000000, REM→0) and go to DONE. Stall=1 this cycle only; the divider is never started.
  - Otherwise go to BUSY with stall=1.
- BUSY:
  - div_start_o=1 and div_keep_o=1.
  - Operand/op ports are driven combinationally from port_a_i/port_b_i/mdu_op_i. The pipeline holds these stable.
  - div_zero_o = (port_b_i==0).
  - When div_stall_req_i=0 (divider in FINISH): capture div_result_i for DIV/DIVU or rem_result_i for REM/REMU. In the same cycle drive div_keep_o=0 so the divider returns to IDLE, then go to DONE.
  - mdu_stall_req_o=1 throughout BUSY.
- DONE:
  - div_start_o=0, stall=0, mdu_result_o stable.
  - Stay while keep_i=1; otherwise go to IDLE.
- Stall formula: mdu_stall_req_o = mdu_req_i && divide op && state!=DONE, forced 0 during overflow/cache-hit completion is not allowed. The stall is high in the request cycle and drops in the first DONE cycle.
- Latency: divider path is divider latency + 1 capture cycle (≈36 cycles for XLEN=32 signed with sign change). Overflow/cache hit takes 1 cycle.
- Divide by zero: no special casing here. The divider returns quotient all-ones and remainder=dividend, and the block passes these through unchanged.
- Kill:
  - kill_i in any state → IDLE next cycle and div_kill_o=kill_i the same cycle.
  - Kill overrides a simultaneous request and a simultaneous capture.
  - mdu_result_o is unchanged and the cache is invalidated.
- Reset mid-operation: same as kill; the divider's own reset also applies.

Optional Feature:
- Macro: MIRISCV_DIV_REM_FUSE_EN.
- Defined:
  - On every divider capture, store port_a, port_b, signedness, quotient and remainder, and set valid.
  - A later IDLE request with equal a, b and signedness but either DIV or REM completes from the cache in 1 cycle (IDLE→DONE); the divider is not started.
  - Invalidated by kill_i or reset.
- Not defined: no cache storage; every non-overflow op goes through BUSY.

Decomposition:
- miriscv_mdu_pkg: existing MDU_OP_* encodings, plus a new div_ctrl_state_t enum (IDLE/BUSY/DONE) and the DIV_OVF_DIVIDEND constant (1<<(XLEN-1)).
- Optional sub-module miriscv_div_fuse_cache, instantiated under the macro: storage, compare, hit output.
- The divider itself is instantiated by the parent MDU, not inside this block.

Test Plan:
- DIVU a=100, b=7, keep_i=0 → result 14. Stall high from the request cycle until div_stall_req_i falls, plus 1 cycle. Divider returns to IDLE.
- REM a=-7 (0xFFFFFFF9), b=2 → result 0xFFFFFFFF. DIV with the same operands → 0xFFFFFFFD.
- DIV a=0x80000000, b=0xFFFFFFFF → result 0x80000000 one cycle later, div_start_o never asserted. REM with the same operands → 0.
- DIVU b=0, a=0x1234 → div_zero_o=1 and result 0xFFFFFFFF. REMU with the same operands → 0x1234.
- kill_i pulsed mid-BUSY (cycle 10) → div_kill_o=1 that cycle, IDLE next cycle, mdu_result_o unchanged. A new DIVU 9/3 afterwards → 3.
- With MIRISCV_DIV_REM_FUSE_EN: DIV 100/7 then REM 100/7 → REM returns 2 in 1 cycle with no div_start_o. REMU 100/7 misses on signedness and runs the full divider.
